// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared 640x480@60 timing constants for the VGA generator and the
// sync decoder, plus the decoder's lock-state encoding and a small
// saturating-increment helper for its 10-bit counters.
package vga_timing_pkg;

  localparam int unsigned HD  = 640;
  localparam int unsigned HFP = 16;
  localparam int unsigned HS  = 96;
  localparam int unsigned HBP = 48;
  localparam int unsigned VD  = 480;
  localparam int unsigned VFP = 10;
  localparam int unsigned VS  = 2;
  localparam int unsigned VBP = 33;

  localparam int unsigned H_TOTAL  = HD + HFP + HS + HBP;
  localparam int unsigned V_TOTAL  = VD + VFP + VS + VBP;
  localparam int unsigned H_OFFSET = HS + HBP;
  localparam int unsigned V_OFFSET = VS + VBP - 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HLOCK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det
// Registers an asynchronous-to-pipeline sync input once, keeps a second
// delayed copy, and flags the cycle in which the registered copy rises.
// Ports:
//   vclk   in  pixel clock
//   reset  in  async active-high reset
//   d      in  raw sync input
//   rise   out high for one cycle after d is first sampled high
module vga_edge_det (
  input  logic vclk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic q;
  logic q_d;

  always_ff @(posedge vclk or posedge reset) begin
    if (reset) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Loopback monitor for a VGA sync/RGB stream. Recovers pixel coordinates
// from the hsync/vsync edges, measures line and frame lengths, runs a
// SEARCH -> HLOCK -> LOCKED lock tracker and pulses h_err / v_err on
// timing violations while locked (or horizontally locked).
// Ports:
//   vclk, reset            pixel clock, async active-high reset
//   hsync_in, vsync_in     active-high syncs
//   rgb_in[2:0]            pixel colour {r,g,b}
//   pix_x, pix_y           recovered column / row (10-bit wrap)
//   pix_data               colour aligned with pix_x/pix_y
//   pix_valid              visible pixel while LOCKED
//   frame_start            one-cycle pulse with pixel (0,0)
//   locked                 lock state is LOCKED
//   line_len               last measured hsync period in vclk
//   frame_lines            last measured vsync period in lines
//   h_err, v_err           one-cycle error pulses
//   err_cnt                saturating error-pulse count
// Timing parameters default to the shared 640x480 set.
module vga_sync_decoder #(
  parameter int unsigned HD  = vga_timing_pkg::HD,
  parameter int unsigned HFP = vga_timing_pkg::HFP,
  parameter int unsigned HS  = vga_timing_pkg::HS,
  parameter int unsigned HBP = vga_timing_pkg::HBP,
  parameter int unsigned VD  = vga_timing_pkg::VD,
  parameter int unsigned VFP = vga_timing_pkg::VFP,
  parameter int unsigned VS  = vga_timing_pkg::VS,
  parameter int unsigned VBP = vga_timing_pkg::VBP
) (
  input  logic       vclk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] rgb_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] pix_data,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_cnt
);

  import vga_timing_pkg::*;

  localparam logic [9:0] H_TOTAL_L = 10'(HD + HFP + HS + HBP);
  localparam logic [9:0] V_TOTAL_L = 10'(VD + VFP + VS + VBP);
  localparam logic [9:0] H_OFF_L   = 10'(HS + HBP);
  localparam logic [9:0] V_OFF_L   = 10'(VS + VBP - 1);
  localparam logic [9:0] HD_L      = 10'(HD);
  localparam logic [9:0] VD_L      = 10'(VD);

  logic       hs_rise;
  logic       vs_rise;
  logic [2:0] rgb_q;

  vga_edge_det u_hs_edge (
    .vclk  (vclk),
    .reset (reset),
    .d     (hsync_in),
    .rise  (hs_rise)
  );

  vga_edge_det u_vs_edge (
    .vclk  (vclk),
    .reset (reset),
    .d     (vsync_in),
    .rise  (vs_rise)
  );

  // Single register stage keeps colour aligned with the sync flops.
  always_ff @(posedge vclk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_in;
  end

  lock_state_t state;
  lock_state_t state_nxt;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [9:0]  hcnt_nxt;
  logic [9:0]  vcnt_nxt;
  logic [9:0]  meas_len;
  logic [9:0]  x_nxt;
  logic [9:0]  y_nxt;
  logic        line_vld;
  logic        line_vld_nxt;
  logic        good_seen;
  logic        good_seen_nxt;
  logic        v_armed;
  logic        v_armed_nxt;
  logic        line_meas;
  logic        line_good;
  logic        frame_good;
  logic        h_err_nxt;
  logic        v_err_nxt;
  logic        visible;
  logic        valid_nxt;

  // A saturated hcnt must report 1023, not wrap to 0.
  assign meas_len   = sat_inc10(hcnt);
  assign line_meas  = hs_rise & line_vld;
  assign line_good  = (meas_len == H_TOTAL_L);
  assign frame_good = (vcnt == V_TOTAL_L);

  always_comb begin
    hcnt_nxt = hs_rise ? '0 : sat_inc10(hcnt);
    vcnt_nxt = vcnt;
    if (vs_rise)      vcnt_nxt = hs_rise ? 10'd1 : '0;
    else if (hs_rise) vcnt_nxt = sat_inc10(vcnt);
  end

  always_comb begin
    state_nxt     = state;
    line_vld_nxt  = line_vld | hs_rise;
    good_seen_nxt = good_seen;
    v_armed_nxt   = v_armed;
    h_err_nxt     = 1'b0;
    v_err_nxt     = 1'b0;
    case (state)
      SEARCH: begin
        if (line_meas) begin
          if (!line_good) begin
            good_seen_nxt = 1'b0;
          end else if (good_seen) begin
            state_nxt     = HLOCK;
            good_seen_nxt = 1'b0;
            v_armed_nxt   = 1'b0;
          end else begin
            good_seen_nxt = 1'b1;
          end
        end
      end
      HLOCK: begin
        if (line_meas && !line_good) begin
          state_nxt     = SEARCH;
          line_vld_nxt  = 1'b0;
          good_seen_nxt = 1'b0;
          v_armed_nxt   = 1'b0;
          h_err_nxt     = 1'b1;
        end else if (vs_rise) begin
          // Each vs rise starts a fresh frame measurement; only an armed
          // one can complete a lock.
          if (v_armed && frame_good) state_nxt = LOCKED;
          v_armed_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (line_meas && !line_good) begin
          state_nxt     = SEARCH;
          line_vld_nxt  = 1'b0;
          good_seen_nxt = 1'b0;
          v_armed_nxt   = 1'b0;
          h_err_nxt     = 1'b1;
        end else if (vs_rise && !frame_good) begin
          state_nxt   = HLOCK;
          v_armed_nxt = 1'b1;
          v_err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt     = SEARCH;
        line_vld_nxt  = 1'b0;
        good_seen_nxt = 1'b0;
        v_armed_nxt   = 1'b0;
      end
    endcase
  end

  // Coordinates are formed from the next counter values so they land in
  // the same register stage as pix_data.
  always_comb begin
    x_nxt     = hcnt_nxt - H_OFF_L;
    y_nxt     = vcnt_nxt - V_OFF_L;
    visible   = (x_nxt < HD_L) && (y_nxt < VD_L);
    valid_nxt = (state_nxt == LOCKED) && visible;
  end

  always_ff @(posedge vclk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      hcnt        <= '0;
      vcnt        <= '0;
      line_vld    <= 1'b0;
      good_seen   <= 1'b0;
      v_armed     <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      err_cnt     <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      vcnt      <= vcnt_nxt;
      line_vld  <= line_vld_nxt;
      good_seen <= good_seen_nxt;
      v_armed   <= v_armed_nxt;
      if (line_meas) line_len    <= meas_len;
      if (vs_rise)   frame_lines <= vcnt;
      h_err <= h_err_nxt;
      v_err <= v_err_nxt;
      if ((h_err_nxt || v_err_nxt) && (err_cnt != '1)) err_cnt <= err_cnt + 8'd1;
      pix_x       <= x_nxt;
      pix_y       <= y_nxt;
      pix_data    <= rgb_q;
      pix_valid   <= valid_nxt;
      frame_start <= valid_nxt && (x_nxt == '0) && (y_nxt == '0);
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: samples the outgoing hsync/vsync/RGB stream on vclk, recovers pixel coordinates, measures line and frame lengths, and reports lock and timing errors. Used in-system as a loopback monitor on the video output and as the checker in generator benches. Sync inputs are active-high.

## Interface
- HD, 640: visible pixels per line
- HFP, 16 / HS, 96 / HBP, 48: horizontal front porch, sync, back porch
- VD, 480: visible lines
- VFP, 10 / VS, 2 / VBP, 33: vertical front porch, sync, back porch
- H_OFFSET, HS+HBP (144): hcnt value of pixel x=0
- V_OFFSET, VS+VBP-1 (34): vcnt value of line y=0
- Clock and reset: reset reset, asynchronous, active-high; clock vclk.
- vclk  in  1  pixel clock
- reset  in  1  async active-high reset
- hsync_in  in  1  horizontal sync, active-high
- vsync_in  in  1  vertical sync, active-high
- rgb_in  in  3  pixel colour {r,g,b}
- pix_x  out  10  recovered column
- pix_y  out  10  recovered row
- pix_data  out  3  colour aligned to pix_x/pix_y
- pix_valid  out  1  visible pixel while LOCKED
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- locked  out  1  state == LOCKED
- line_len  out  10  last measured hsync period (vclk)
- frame_lines  out  10  last measured vsync period (lines)
- h_err  out  1  one-cycle pulse, bad line length
- v_err  out  1  one-cycle pulse, bad frame length
- err_cnt  out  8  saturating count of h_err+v_err pulses

## Operation
- Input stage: hsync_in, vsync_in, rgb_in registered once (hs_q, vs_q, rgb_q); second register on hs_q/vs_q for rise detect.
- hcnt (10 b): 0 in cycle of hs rise, else +1, saturates 1023. On rise (not first after reset/SEARCH entry): line_len <= hcnt+1; good iff == H_TOTAL = HD+HFP+HS+HBP (800).
- vcnt (10 b): +1 on each hs rise, saturates 1023. On vs rise: frame_lines <= vcnt, vcnt <= 0; coincident hs rise -> vcnt <= 1. Good frame iff frame_lines == V_TOTAL = VD+VFP+VS+VBP (525).
- Coordinates: pix_x = hcnt-H_OFFSET, pix_y = vcnt-V_OFFSET (10-bit wrap). Visible iff both in [0,HD)/[0,VD).
- Lock FSM: SEARCH -> HLOCK after 2 consecutive good lines. HLOCK: first vs rise arms measurement; next vs rise with good frame -> LOCKED, bad -> stay HLOCK, re-arm. Any bad line in HLOCK/LOCKED -> SEARCH + h_err. Bad frame in LOCKED -> HLOCK (armed) + v_err.
- pix_valid = LOCKED && visible. frame_start = pix_valid && pix_x==0 && pix_y==0.
- err_cnt += 1 per error pulse, saturates 255; h_err and v_err never both asserted.
- hsync stuck: hcnt saturates; next rise gives line_len 1023 -> bad.

## Timing
- Reset: all outputs 0, state SEARCH, counters 0, line-valid flag cleared.
- pix_x/pix_y/pix_data/pix_valid/frame_start registered; 2 vclk after the rgb_in sample they describe; pixel of hcnt=0 is the input sample at the hsync_in rising cycle.
- line_len/frame_lines/h_err/v_err/locked update 2 vclk after the causing sync edge at the input.
- Reset mid-line: counters restart; first post-reset hs rise is not measured.

## Structure
- Package vga_timing_pkg: HD..VBP, H_TOTAL, V_TOTAL, lock-state enum {SEARCH,HLOCK,LOCKED}; shared with the generator.
- Sub-module vga_edge_det: two-flop register + rise pulse, instantiated for hsync and vsync.

## Test plan
- Ideal 640x480 stream from generator model, 3 frames -> locked after second vsync rise, err_cnt 0, line_len 800, frame_lines 525.
- Locked, one line 799 cycles -> h_err pulse, err_cnt 1, state SEARCH, pix_valid 0 until re-lock.
- Locked, frame of 524 lines -> v_err, HLOCK, relock after next good frame.
- rgb_in = pix-index pattern -> pix_data matches expected colour at every (x,y); frame_start exactly once per frame at (0,0).
- hsync held low 2000 cycles -> line_len 1023, h_err, no counter overflow.
- Reset asserted mid-frame -> all outputs 0 next cycle; relock in two frames.
